conv5_wt_mac: RTL and testbench

Layer-5 convolution MAC stage that sits directly downstream of the layer-5 dual-port weight ROM. It drives both ROM address ports, two consecutive weight words per beat. Each 144-bit word holds nine signed 16-bit 3x3 kernel taps. It multiplies those taps against two streamed 3x3 activation windows and accumulates over all DEPTH words. It then presents one rescaled output pixel on a valid/ready port.

---
 rtl/conv5_wt_mac.sv | 165 ++++++++++++++++
 tb/tb_conv5_wt_mac.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv5_wt_mac.sv
// conv5_wt_mac: layer-5 convolution MAC stage.
// It drives both ports of the layer-5 weight ROM, two words per beat. Each beat
// is multiplied against two streamed 3x3 activation windows, and the result is
// accumulated over DEPTH words. One rescaled pixel is then presented on a
// valid/ready port.
// Optional feature: define CONV5_SAT_EN to saturate the output instead of
// wrapping it.
module conv5_wt_mac #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 76,
  parameter int TAP_W      = 16,
  parameter int ACC_W      = 48,
  parameter int FRAC       = 12,
  parameter int OUT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  input  logic                  win_valid,
  output logic                  win_ready,
  input  logic [9*TAP_W-1:0]    win_a,
  input  logic [9*TAP_W-1:0]    win_b,
  output logic [ADDR_WIDTH-1:0] wt_addr_a,
  output logic [ADDR_WIDTH-1:0] wt_addr_b,
  input  logic [9*TAP_W-1:0]    wt_q_a,
  input  logic [9*TAP_W-1:0]    wt_q_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data
);

  localparam int NPAIR = DEPTH / 2;
  localparam int PC_W  = $clog2(NPAIR + 1);
  localparam int WIN_W = 9 * TAP_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                  state;
  logic [PC_W-1:0]         pc;
  logic                    v1;
  logic                    v2;
  logic [WIN_W-1:0]        act_a;
  logic [WIN_W-1:0]        act_b;
  logic signed [ACC_W-1:0] psum;
  logic signed [ACC_W-1:0] psum_next;
  logic signed [ACC_W-1:0] acc;
  logic                    win_hs;

  // The multiply is done at full product width.
  // The product is then sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic signed [TAP_W-1:0] a,
    input logic signed [TAP_W-1:0] b
  );
    logic signed [2*TAP_W-1:0] p;
    p = a * b;
    return {{(ACC_W-2*TAP_W){p[2*TAP_W-1]}}, p};
  endfunction

  assign win_ready = (state == RUN) && (pc < PC_W'(NPAIR));
  assign win_hs    = win_valid && win_ready;
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);

  // ROM addresses come straight from pc.
  // This lets the ROM sample the beat's word pair on the handshake edge.
  assign wt_addr_a = ADDR_WIDTH'({pc, 1'b0});
  assign wt_addr_b = ADDR_WIDTH'({pc, 1'b1});

  // The partial sum covers the 18 tap products of one beat.
  // The weights come from the ROM one cycle after the handshake.
  // The activations were latched on that same handshake edge.
  always_comb begin
    psum_next = '0;
    for (int i = 0; i < 9; i++) begin
      psum_next = psum_next
                + mul_ext(wt_q_a[TAP_W*i +: TAP_W], act_a[TAP_W*i +: TAP_W])
                + mul_ext(wt_q_b[TAP_W*i +: TAP_W], act_b[TAP_W*i +: TAP_W]);
    end
  end

  // Control FSM, beat counter, pipeline valids and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      acc   <= '0;
      act_a <= '0;
      act_b <= '0;
    end else begin
      v1 <= win_hs;
      v2 <= v1;
      if (v2) begin
        acc <= acc + psum;
      end
      if (win_hs) begin
        act_a <= win_a;
        act_b <= win_b;
        pc    <= pc + PC_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            pc    <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            acc   <= '0;
          end
        end
        RUN: begin
          if (win_hs && (pc == PC_W'(NPAIR - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (v2 && !v1) begin
            state <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The partial-sum register is loaded only for real beats.
  // Bubbles leave it untouched, and v2 masks the bubbles out of the accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum <= '0;
    end else if (v1) begin
      psum <= psum_next;
    end
  end

`ifdef CONV5_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

  logic signed [ACC_W-1:0] shifted;

  // Clamp the rescaled accumulator into the signed output range.
  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted > OUT_MAX) begin
      out_data = OUT_W'(OUT_MAX);
    end else if (shifted < OUT_MIN) begin
      out_data = OUT_W'(OUT_MIN);
    end else begin
      out_data = OUT_W'(shifted);
    end
  end
`else
  assign out_data = OUT_W'(acc >>> FRAC);
`endif

endmodule

// File: tb/tb_conv5_wt_mac.sv
// tb_conv5_wt_mac: directed bench for conv5_wt_mac.
// It includes a registered dual-port ROM model and a behavioural reference sum.
module tb_conv5_wt_mac;

  localparam int NPAIR = 38;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         win_valid = 1'b0;
  logic         win_ready;
  logic [143:0] win_a = '0;
  logic [143:0] win_b = '0;
  logic [6:0]   wt_addr_a;
  logic [6:0]   wt_addr_b;
  logic [143:0] wt_q_a = '0;
  logic [143:0] wt_q_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [15:0]  out_data;

  logic [143:0] rom [76];

  int checks = 0;
  int errors = 0;

  logic [15:0] res;
  int          lat, beats, aerr, derr, herr;
  bit          tout;

  conv5_wt_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_a     (win_a),
    .win_b     (win_b),
    .wt_addr_a (wt_addr_a),
    .wt_addr_b (wt_addr_b),
    .wt_q_a    (wt_q_a),
    .wt_q_b    (wt_q_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Weight ROM with one cycle of registered read latency.
  always @(posedge clk) begin
    wt_q_a <= (int'(wt_addr_a) < 76) ? rom[wt_addr_a] : '0;
    wt_q_b <= (int'(wt_addr_b) < 76) ? rom[wt_addr_b] : '0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] romTap(input int mode, input int w, input int i);
    case (mode)
      0:       return 16'h1000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      default: return 16'((((w * 7 + i * 11) % 61) - 30) * 64);
    endcase
  endfunction

  function automatic logic [15:0] actTap(input int mode, input int beat, input int side,
                                         input int i);
    case (mode)
      0:       return 16'h0010;
      1:       return 16'h7FFF;
      default: return 16'((beat * 3 + i * 5 - 40 + side * 7) * 16);
    endcase
  endfunction

  function automatic logic [143:0] actWord(input int mode, input int beat, input int side);
    logic [143:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[16*i +: 16] = actTap(mode, beat, side, i);
    return w;
  endfunction

  function automatic longint expectedSum(input int rmode, input int amode);
    longint s;
    s = 0;
    for (int b = 0; b < NPAIR; b++)
      for (int side = 0; side < 2; side++)
        for (int i = 0; i < 9; i++)
          s += longint'($signed(romTap(rmode, 2 * b + side, i)))
             * longint'($signed(actTap(amode, b, side, i)));
    return s;
  endfunction

  function automatic logic [15:0] expectedOut(input longint s);
    longint sh;
    sh = s >>> 12;
`ifdef CONV5_SAT_EN
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
`endif
    return sh[15:0];
  endfunction

  task automatic loadRom(input int mode);
    for (int w = 0; w < 76; w++)
      for (int i = 0; i < 9; i++) rom[w][16*i +: 16] = romTap(mode, w, i);
  endtask

  // Run one pixel.
  // abort_beat >= 0 pulls reset once that many beats have been accepted.
  task automatic applyStimulus(input int amode, input bit bubbles, input int hold,
                               input int abort_beat, output logic [15:0] result,
                               output int latency, output int nbeats, output int addr_err,
                               output int drain_err, output int hold_err, output bit timed_out);
    bit done, toggle;
    done = 0; toggle = 1; latency = 0; nbeats = 0; addr_err = 0; drain_err = 0;
    hold_err = 0; timed_out = 0; result = '0;
    out_ready = (hold == 0);
    @(negedge clk);
    start = 1'b1;
    win_valid = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      start = 1'b0;
      latency++;
      if (out_valid) begin
        done = 1;
      end else begin
        if (nbeats == abort_beat) begin
          rst_n = 1'b0;
          #1;
          checkOutput("reset_midrun", {busy, win_ready, out_valid, out_data, wt_addr_a, wt_addr_b},
                      {3'b000, 16'h0000, 7'd0, 7'd1});
          win_valid = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (nbeats >= NPAIR && win_ready) drain_err++;
        win_valid = (nbeats < NPAIR) && (!bubbles || toggle);
        toggle = ~toggle;
        win_a = actWord(amode, nbeats, 0);
        win_b = actWord(amode, nbeats, 1);
        if (win_valid && win_ready) begin
          if (wt_addr_a != 7'(2 * nbeats) || wt_addr_b != 7'(2 * nbeats + 1)) addr_err++;
          nbeats++;
        end
      end
    end
    win_valid = 1'b0;
    if (!done) begin
      timed_out = 1;
      return;
    end
    result = out_data;
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      @(negedge clk);
      if (out_data != result || !busy || !out_valid) hold_err++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    loadRom(0);
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {busy, win_ready, out_valid, out_data, wt_addr_a, wt_addr_b},
                {3'b000, 16'h0000, 7'd0, 7'd1});
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic: unit taps, constant activations");
    applyStimulus(0, 0, 0, -1, res, lat, beats, aerr, derr, herr, tout);
    checkOutput("basic_timeout", 64'(tout), 64'd0);
    checkOutput("basic_data", 64'(res), 64'h2AC0);
    checkOutput("basic_latency", 64'(lat), 64'd41);
    checkOutput("basic_beats", 64'(beats), 64'd38);
    checkOutput("basic_addr", 64'(aerr), 64'd0);
    checkOutput("basic_drain_ready", 64'(derr), 64'd0);
    checkOutput("basic_idle", {busy, out_valid}, 2'b00);

    $display("[TB] bubbles: win_valid toggling");
    applyStimulus(0, 1, 0, -1, res, lat, beats, aerr, derr, herr, tout);
    checkOutput("bubble_timeout", 64'(tout), 64'd0);
    checkOutput("bubble_data", 64'(res), 64'h2AC0);
    checkOutput("bubble_beats", 64'(beats), 64'd38);
    checkOutput("bubble_addr", 64'(aerr), 64'd0);

    $display("[TB] varied taps and activations");
    loadRom(3);
    applyStimulus(2, 0, 0, -1, res, lat, beats, aerr, derr, herr, tout);
    checkOutput("varied_data", 64'(res), 64'(expectedOut(expectedSum(3, 2))));

    $display("[TB] positive overflow");
    loadRom(1);
    applyStimulus(1, 0, 0, -1, res, lat, beats, aerr, derr, herr, tout);
    checkOutput("pos_ovf_data", 64'(res), 64'(expectedOut(expectedSum(1, 1))));

    $display("[TB] negative overflow");
    loadRom(2);
    applyStimulus(1, 0, 0, -1, res, lat, beats, aerr, derr, herr, tout);
    checkOutput("neg_ovf_data", 64'(res), 64'(expectedOut(expectedSum(2, 1))));

    $display("[TB] backpressure with start pulses");
    loadRom(0);
    applyStimulus(0, 0, 10, -1, res, lat, beats, aerr, derr, herr, tout);
    checkOutput("bp_data", 64'(res), 64'h2AC0);
    checkOutput("bp_hold_stable", 64'(herr), 64'd0);
    checkOutput("bp_idle", {busy, out_valid}, 2'b00);

    $display("[TB] reset mid-run then fresh pixel");
    loadRom(3);
    applyStimulus(2, 0, 0, 20, res, lat, beats, aerr, derr, herr, tout);
    applyStimulus(2, 0, 0, -1, res, lat, beats, aerr, derr, herr, tout);
    checkOutput("fresh_timeout", 64'(tout), 64'd0);
    checkOutput("fresh_data", 64'(res), 64'(expectedOut(expectedSum(3, 2))));
    checkOutput("fresh_latency", 64'(lat), 64'd41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
